// File: rtl/mig_wr_burst_gen_if.sv
// Bus bundle between the write-burst generator, its show-ahead data FIFO
// and the MIG write controller.
interface mig_wr_burst_gen_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 11
);
  // show-ahead FIFO side
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_rd_cnt;
  logic              fifo_rd_en;

  // write controller side
  logic              wr_req;
  logic [ADDR_W-1:0] wr_req_addr;
  logic [15:0]       wr_length;
  logic [DATA_W-1:0] wr_data;
  logic              wr_busy;
  logic              wr_data_valid;
  logic              wr_done;

  // generator view
  modport master (
    input  fifo_rd_data, fifo_empty, fifo_rd_cnt,
    output fifo_rd_en,
    output wr_req, wr_req_addr, wr_length, wr_data,
    input  wr_busy, wr_data_valid, wr_done
  );

  // FIFO + controller view
  modport slave (
    output fifo_rd_data, fifo_empty, fifo_rd_cnt,
    input  fifo_rd_en,
    input  wr_req, wr_req_addr, wr_length, wr_data,
    output wr_busy, wr_data_valid, wr_done
  );
endinterface

// File: rtl/mig_wr_burst_gen.sv
// Write-burst generator: drains a show-ahead FIFO into a fixed DDR frame
// region, one wr_req per burst, wrapping to the region base at frame end.
module mig_wr_burst_gen #(
  parameter int                ADDR_W      = 28,
  parameter int                DATA_W      = 128,
  parameter int                BURST_LEN   = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                FRAME_BEATS = 1024,
  parameter int                ADDR_STEP   = 8,
  parameter int                CNT_W       = 11
) (
  input  logic                ui_clk,
  input  logic                rst,
  input  logic                enable,
  mig_wr_burst_gen_if.master  bus,
  output logic                frame_done,
  output logic                err_underflow
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_REQ   = 2'd2;
  localparam logic [1:0] S_BURST = 2'd3;

  localparam logic [23:0]       BURST_LEN_W = 24'(BURST_LEN);
  localparam logic [23:0]       FRAME_W     = 24'(FRAME_BEATS);
  localparam logic [ADDR_W-1:0] STEP        = ADDR_W'(ADDR_STEP);
  localparam logic [15:0]       INIT_LEN    = (FRAME_BEATS < BURST_LEN) ?
                                              16'(FRAME_BEATS) : 16'(BURST_LEN);

  logic [1:0]        state;
  logic [ADDR_W-1:0] cur_addr;
  logic [23:0]       beats_left;
  logic [15:0]       next_len;
  logic [23:0]       beats_after;
  logic [ADDR_W-1:0] addr_after;
  logic              start_ok;
  logic              in_burst;
  logic [CNT_W-1:0]  avail;
  logic [DATA_W-1:0] head_word;

  assign avail     = bus.fifo_rd_cnt;
  assign head_word = bus.fifo_rd_data;
  assign in_burst  = (state == S_BURST);

  // The controller always sees the FIFO head; wr_req is the REQ state itself
  // and the pop is zero-latency so the show-ahead head advances with each beat.
  assign bus.wr_data    = head_word;
  assign bus.wr_req     = (state == S_REQ);
  assign bus.fifo_rd_en = in_burst & bus.wr_data_valid & ~bus.fifo_empty;

  // Next burst size, post-burst position and the WAIT->REQ launch condition.
  always_comb begin
    next_len    = (beats_left < BURST_LEN_W) ? beats_left[15:0] : BURST_LEN_W[15:0];
    beats_after = beats_left - 24'(bus.wr_length);
    addr_after  = cur_addr + ADDR_W'(bus.wr_length) * STEP;
    start_ok    = (24'(avail) >= 24'(next_len)) && !bus.wr_busy;
  end

  // Burst sequencer: frame position, latched request fields and frame pulse.
  always_ff @(posedge ui_clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      cur_addr        <= BASE_ADDR;
      beats_left      <= FRAME_W;
      bus.wr_req_addr <= BASE_ADDR;
      bus.wr_length   <= INIT_LEN;
      frame_done      <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          cur_addr   <= BASE_ADDR;
          beats_left <= FRAME_W;
          if (enable) state <= S_WAIT;
        end
        S_WAIT: begin
          if (!enable) begin
            state <= S_IDLE;
          end else if (start_ok) begin
            bus.wr_req_addr <= cur_addr;
            bus.wr_length   <= next_len;
            state           <= S_REQ;
          end
        end
        S_REQ: begin
          state <= S_BURST;
        end
        S_BURST: begin
          if (bus.wr_done) begin
            if (beats_after == 24'd0) begin
              frame_done <= 1'b1;
              cur_addr   <= BASE_ADDR;
              beats_left <= FRAME_W;
            end else begin
              cur_addr   <= addr_after;
              beats_left <= beats_after;
            end
            state <= enable ? S_WAIT : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sticky flag for a beat consumed while the FIFO had nothing to give.
  always_ff @(posedge ui_clk or posedge rst) begin
    if (rst) begin
      err_underflow <= 1'b0;
    end else if (in_burst && bus.wr_data_valid && bus.fifo_empty) begin
      err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mig_wr_burst_gen.sv
// Directed bench for mig_wr_burst_gen: small frame (base 0x100, 4-beat bursts,
// 10-beat frame), a bench-owned show-ahead FIFO and a scripted controller.
module tb_mig_wr_burst_gen;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  localparam int CNT_W  = 11;

  logic ui_clk = 1'b0;
  logic rst;
  logic enable;
  logic frame_done;
  logic err_underflow;

  logic wr_busy;
  logic wr_data_valid;
  logic wr_done;
  logic force_empty;

  logic [DATA_W-1:0] mem [0:63];
  int wr_ptr;
  int rd_ptr;
  int pop_count;
  int valid_count;
  int exp_idx;
  int n_checks;
  int n_fail;

  mig_wr_burst_gen_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  mig_wr_burst_gen #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(4), .BASE_ADDR(28'h100),
    .FRAME_BEATS(10), .ADDR_STEP(8), .CNT_W(CNT_W)
  ) dut (
    .ui_clk(ui_clk), .rst(rst), .enable(enable), .bus(bus),
    .frame_done(frame_done), .err_underflow(err_underflow)
  );

  // Free-running MIG user clock, 10 time units per cycle.
  always #5 ui_clk = ~ui_clk;

  // Show-ahead FIFO model: head is mem[rd_ptr], level is the pointer gap.
  assign bus.fifo_rd_data  = mem[rd_ptr[5:0]];
  assign bus.fifo_empty    = force_empty || (wr_ptr == rd_ptr);
  assign bus.fifo_rd_cnt   = CNT_W'(wr_ptr - rd_ptr);
  assign bus.wr_busy       = wr_busy;
  assign bus.wr_data_valid = wr_data_valid;
  assign bus.wr_done       = wr_done;

  // Pops advance the FIFO head and are tallied for the pop-count checks.
  always @(posedge ui_clk) begin
    if (bus.fifo_rd_en) begin
      rd_ptr    <= rd_ptr + 1;
      pop_count <= pop_count + 1;
    end
  end

  // Safety net so a stuck run still ends with a visible failure.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [DATA_W-1:0] word(input int i);
    return {96'hFEED_BEEF_CAFE_0000_5A5A_0000, 32'(i)};
  endfunction

  task automatic tick();
    @(posedge ui_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic done);
    wr_data_valid = valid;
    wr_done       = done;
  endtask

  task automatic push(input int n);
    for (int k = 0; k < n; k++) begin
      mem[wr_ptr[5:0]] = word(wr_ptr);
      wr_ptr++;
    end
  endtask

  // Wait (bounded) for wr_req; optionally require an exact cycle count.
  task automatic wait_req(input int exp_wait);
    int waited;
    waited = 0;
    while (!bus.wr_req && waited < 40) begin
      tick();
      waited++;
    end
    checkOutput("wr_req seen", 128'(bus.wr_req), 128'(1'b1));
    if (exp_wait >= 0) checkOutput("wr_req latency", 128'(waited), 128'(exp_wait));
  endtask

  task automatic check_req(input logic [ADDR_W-1:0] addr, input logic [15:0] len);
    checkOutput("wr_req_addr", 128'(bus.wr_req_addr), 128'(addr));
    checkOutput("wr_length", 128'(bus.wr_length), 128'(len));
  endtask

  // Called in the first BURST cycle; feeds len beats with gap idle cycles
  // before each, checking pops, data order and request-field stability.
  task automatic drive_beats(input int len, input int gap,
                             input logic [ADDR_W-1:0] addr, input logic [15:0] blen);
    for (int b = 0; b < len; b++) begin
      for (int g = 0; g < gap; g++) begin
        applyStimulus(1'b0, 1'b0);
        #1 checkOutput("no pop in gap", 128'(bus.fifo_rd_en), 128'(1'b0));
        tick();
      end
      applyStimulus(1'b1, (b == len - 1));
      valid_count++;
      #1;
      checkOutput("pop on valid", 128'(bus.fifo_rd_en), 128'(1'b1));
      checkOutput("wr_data order", bus.wr_data, word(exp_idx));
      checkOutput("addr stable", 128'(bus.wr_req_addr), 128'(addr));
      checkOutput("len stable", 128'(bus.wr_length), 128'(blen));
      tick();
      exp_idx++;
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("pop count", 128'(pop_count), 128'(valid_count));
  endtask

  typedef struct {
    int                gap;
    int                exp_wait;
    logic [ADDR_W-1:0] exp_addr;
    logic [15:0]       exp_len;
    logic              exp_fd;
  } vec_t;

  vec_t vecs [6];

  initial begin
    // two full frames: first back-to-back, second with back-pressure gaps
    vecs[0] = '{gap: 0, exp_wait: -1, exp_addr: 28'h100, exp_len: 16'd4, exp_fd: 1'b0};
    vecs[1] = '{gap: 0, exp_wait:  1, exp_addr: 28'h120, exp_len: 16'd4, exp_fd: 1'b0};
    vecs[2] = '{gap: 0, exp_wait:  1, exp_addr: 28'h140, exp_len: 16'd2, exp_fd: 1'b1};
    vecs[3] = '{gap: 2, exp_wait:  1, exp_addr: 28'h100, exp_len: 16'd4, exp_fd: 1'b0};
    vecs[4] = '{gap: 2, exp_wait:  1, exp_addr: 28'h120, exp_len: 16'd4, exp_fd: 1'b0};
    vecs[5] = '{gap: 1, exp_wait:  1, exp_addr: 28'h140, exp_len: 16'd2, exp_fd: 1'b1};

    n_checks = 0; n_fail = 0;
    wr_ptr = 0; rd_ptr = 0; pop_count = 0; valid_count = 0; exp_idx = 0;
    rst = 1'b1; enable = 1'b0; wr_busy = 1'b0; force_empty = 1'b0;
    applyStimulus(1'b0, 1'b0);
    push(20);
    tick();
    tick();

    // reset values
    checkOutput("rst wr_req", 128'(bus.wr_req), 128'(1'b0));
    checkOutput("rst wr_req_addr", 128'(bus.wr_req_addr), 128'(28'h100));
    checkOutput("rst wr_length", 128'(bus.wr_length), 128'(16'd4));
    checkOutput("rst frame_done", 128'(frame_done), 128'(1'b0));
    checkOutput("rst err_underflow", 128'(err_underflow), 128'(1'b0));
    checkOutput("rst fifo_rd_en", 128'(bus.fifo_rd_en), 128'(1'b0));
    checkOutput("rst wr_data", bus.wr_data, word(0));

    rst = 1'b0;
    enable = 1'b1;

    // basic frame and back-pressure frame from the vector table
    for (int v = 0; v < 6; v++) begin
      wait_req(vecs[v].exp_wait);
      check_req(vecs[v].exp_addr, vecs[v].exp_len);
      tick();
      drive_beats(int'(vecs[v].exp_len), vecs[v].gap, vecs[v].exp_addr, vecs[v].exp_len);
      checkOutput("frame_done", 128'(frame_done), 128'(vecs[v].exp_fd));
    end

    // starved FIFO: 3 words never launch a 4-beat burst; stray beats ignored
    push(3);
    for (int c = 0; c < 6; c++) begin
      applyStimulus(c == 2, c == 2);
      #1 checkOutput("starved no pop", 128'(bus.fifo_rd_en), 128'(1'b0));
      checkOutput("starved no req", 128'(bus.wr_req), 128'(1'b0));
      tick();
    end
    applyStimulus(1'b0, 1'b0);
    push(1);
    tick();
    checkOutput("req 1 cycle after level", 128'(bus.wr_req), 128'(1'b1));
    check_req(28'h100, 16'd4);
    tick();
    drive_beats(4, 0, 28'h100, 16'd4);

    // busy controller holds off the launch even with data available
    wr_busy = 1'b1;
    push(10);
    for (int c = 0; c < 5; c++) begin
      tick();
      checkOutput("busy no req", 128'(bus.wr_req), 128'(1'b0));
    end
    wr_busy = 1'b0;
    wait_req(1);
    check_req(28'h120, 16'd4);

    // enable drop mid-burst: burst finishes, position discarded
    tick();
    enable = 1'b0;
    drive_beats(4, 0, 28'h120, 16'd4);
    checkOutput("drop frame_done", 128'(frame_done), 128'(1'b0));
    for (int c = 0; c < 8; c++) begin
      checkOutput("disabled no req", 128'(bus.wr_req), 128'(1'b0));
      tick();
    end
    enable = 1'b1;
    wait_req(2);
    check_req(28'h100, 16'd4);
    tick();
    drive_beats(4, 0, 28'h100, 16'd4);

    // underflow: beat with empty FIFO sets the sticky flag, no pop
    push(2);
    wait_req(-1);
    check_req(28'h120, 16'd4);
    tick();
    force_empty = 1'b1;
    applyStimulus(1'b1, 1'b0);
    #1 checkOutput("underflow no pop", 128'(bus.fifo_rd_en), 128'(1'b0));
    checkOutput("underflow not yet", 128'(err_underflow), 128'(1'b0));
    tick();
    checkOutput("underflow set", 128'(err_underflow), 128'(1'b1));
    force_empty = 1'b0;
    applyStimulus(1'b0, 1'b0);
    drive_beats(4, 0, 28'h120, 16'd4);
    checkOutput("underflow sticky", 128'(err_underflow), 128'(1'b1));

    // async reset mid-burst, between clock edges
    push(2);
    wait_req(-1);
    check_req(28'h140, 16'd2);
    tick();
    applyStimulus(1'b1, 1'b0);
    #1 checkOutput("pre-reset data", bus.wr_data, word(exp_idx));
    checkOutput("pre-reset err", 128'(err_underflow), 128'(1'b1));
    #2 rst = 1'b1;
    #1;
    checkOutput("async wr_req", 128'(bus.wr_req), 128'(1'b0));
    checkOutput("async wr_req_addr", 128'(bus.wr_req_addr), 128'(28'h100));
    checkOutput("async wr_length", 128'(bus.wr_length), 128'(16'd4));
    checkOutput("async err cleared", 128'(err_underflow), 128'(1'b0));
    checkOutput("async fifo_rd_en", 128'(bus.fifo_rd_en), 128'(1'b0));
    checkOutput("async frame_done", 128'(frame_done), 128'(1'b0));
    applyStimulus(1'b0, 1'b0);
    tick();
    rst = 1'b0;
    checkOutput("reset no pop", 128'(pop_count), 128'(valid_count));
    for (int c = 0; c < 4; c++) begin
      tick();
      checkOutput("post-reset starved", 128'(bus.wr_req), 128'(1'b0));
    end
    push(2);
    wait_req(-1);
    check_req(28'h100, 16'd4);
    tick();
    drive_beats(4, 0, 28'h100, 16'd4);
    checkOutput("post-reset frame_done", 128'(frame_done), 128'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mig_wr_burst_gen.md
# mig_wr_burst_gen

Write-burst generator that sits directly upstream of the MIG write controller (`mig_ctrl_wr`). It drains a show-ahead data FIFO into DDR, carving a fixed-size frame region into bursts. For each burst it issues a single-cycle `wr_req` with address and length. It then streams FIFO words to the controller on each `wr_data_valid` and advances the DDR address, wrapping to the region base at frame end.

## Interface
Parameters:
- `ADDR_W`, 28 — DDR address width
- `DATA_W`, 128 — data word width (one MIG beat)
- `BURST_LEN`, 64 — beats per normal burst, 1..65535
- `BASE_ADDR`, 28'h0 — first address of frame region
- `FRAME_BEATS`, 1024 — beats per frame, 1..2^24-1
- `ADDR_STEP`, 8 — address increment per beat (4:1 clock ratio, BL8)
- `CNT_W`, 11 — width of FIFO read count

Ports:
- `ui_clk`  in  1  — MIG user clock; single clock domain
- `rst`  in  1  — asynchronous, active-high reset
- `enable`  in  1  — level; high = run, low = stop after current burst
- `fifo_rd_data`  in  DATA_W  — show-ahead FIFO head word
- `fifo_empty`  in  1  — FIFO empty
- `fifo_rd_cnt`  in  CNT_W  — words available in FIFO
- `fifo_rd_en`  out  1  — pop FIFO head
- `wr_req`  out  1  — one-cycle burst request to write controller
- `wr_req_addr`  out  ADDR_W  — burst start address
- `wr_length`  out  16  — burst length in beats
- `wr_data`  out  DATA_W  — write data; equals `fifo_rd_data` combinationally
- `wr_busy`  in  1  — write controller busy
- `wr_data_valid`  in  1  — controller consumed `wr_data` this cycle
- `wr_done`  in  1  — last beat of burst accepted; coincides with final `wr_data_valid`
- `frame_done`  out  1  — one-cycle pulse when the last burst of a frame completes
- `err_underflow`  out  1  — sticky; `wr_data_valid` seen while FIFO empty

## Operation
- States: IDLE, WAIT, REQ, BURST.
- IDLE:
  - `cur_addr = BASE_ADDR`, `beats_left = FRAME_BEATS`.
  - Go to WAIT when `enable` = 1.
- WAIT:
  - `next_len = min(BURST_LEN, beats_left)`.
  - Go to REQ when `fifo_rd_cnt >= next_len` and `wr_busy` = 0.
  - Go to IDLE if `enable` = 0 (position reset).
- REQ:
  - `wr_req` = 1 for exactly this cycle.
  - Latch `wr_req_addr = cur_addr` and `wr_length = next_len`.
  - Go to BURST next cycle unconditionally.
- BURST:
  - `fifo_rd_en = wr_data_valid & ~fifo_empty`.
  - On `wr_done`:
    - `cur_addr += wr_length*ADDR_STEP` (mod 2^ADDR_W).
    - `beats_left -= wr_length`.
  - If the result is 0: pulse `frame_done`, reload `cur_addr = BASE_ADDR` and `beats_left = FRAME_BEATS`.
  - Then go to WAIT if `enable` = 1, else IDLE.
- `enable` falling during REQ or BURST:
  - The burst completes normally.
  - Then go to IDLE, discarding partial-frame position.
- `err_underflow`:
  - Set when `wr_data_valid & fifo_empty`.
  - Cleared only by `rst`.
  - The pop is suppressed; the controller still receives the stale `fifo_rd_data`.
- `wr_data_valid` or `wr_done` outside BURST: ignored; no pop, no counter change.
- Arithmetic:
  - `beats_left` is 24 bits.
  - Address math is ADDR_W bits with natural wrap.
  - `wr_length*ADDR_STEP` is computed at ADDR_W width.

## Timing
- Reset values: all outputs 0, except:
  - `wr_req_addr = BASE_ADDR`
  - `wr_length = min(BURST_LEN, FRAME_BEATS)`
  - `wr_data` follows `fifo_rd_data`
- Reset state: IDLE with `beats_left = FRAME_BEATS`.
- Reset mid-burst: state, counters and sticky error are cleared immediately (asynchronous). Recovery of the downstream controller is the system's responsibility.
- WAIT→REQ decision is registered: `wr_req` rises one cycle after the condition is seen.
- `wr_req_addr` and `wr_length` are stable from the REQ cycle through the cycle of `wr_done`.
- `fifo_rd_en` is combinational from `wr_data_valid`: zero-latency pop, as a show-ahead FIFO requires.
- `frame_done` is registered and is high the cycle after the final `wr_done`.
- Minimum gap between bursts: `wr_done` cycle → WAIT (1) → REQ (1), so `wr_req` is at best 2 cycles after `wr_done`.
- WAIT never fires while `wr_busy` = 1. This holds even when the FIFO level is sufficient.

## Test plan
- **Basic frame.** Config: `BASE_ADDR`=0x100, `BURST_LEN`=4, `FRAME_BEATS`=10, FIFO preloaded with 10 words, `enable`=1.
  - Three `wr_req`: (0x100, 4), (0x120, 4), (0x140, 2).
  - 10 pops in order.
  - `frame_done` pulse one cycle after the third `wr_done`.
  - Next request at 0x100.
- **Starved FIFO.** Same config, `fifo_rd_cnt`=3.
  - No `wr_req` while the count stays at 3.
  - Raise the count to 4 → `wr_req` (0x100, 4) exactly 1 cycle later.
- **Back-pressure.** Model `wr_data_valid` with random gaps (e.g. 1 of 3 cycles high).
  - Pops equal `wr_data_valid` count.
  - `wr_req_addr` and `wr_length` stay constant through each burst.
  - Data order is preserved.
- **Enable drop mid-burst.** Drop `enable` during the second burst.
  - The burst completes.
  - State returns to IDLE; no further `wr_req`.
  - Re-enable → first request at 0x100.
- **Underflow.** Force `fifo_empty`=1 with `wr_data_valid`=1 in BURST.
  - `err_underflow` = 1 next cycle and stays high.
  - `fifo_rd_en` = 0 that cycle.
  - Only `rst` clears the error.
- **Async reset.** Assert `rst` mid-burst, off a clock edge.
  - All outputs reach reset values without a clock.
  - After release with `enable`=1, the first `wr_req` is at `BASE_ADDR`.
